// File: rtl/ad7771_dout_reader_mc_if.sv
// rtl/ad7771_dout_reader_mc_if.sv - published frame bus of the AD7771 multi-lane DOUT reader
// The reader drives it through the master modport; downstream filtering logic consumes it through slave.
interface ad7771_dout_reader_mc_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 24,
  parameter int HDR_W  = 8
);
  logic [NUM_CH*DATA_W-1:0] data_o;
  logic [NUM_CH*HDR_W-1:0]  header_o;
  logic                     valid_o;
  logic                     frame_err_o;
  logic [15:0]              err_cnt_o;

  modport master (
    output data_o,
    output header_o,
    output valid_o,
    output frame_err_o,
    output err_cnt_o
  );

  modport slave (
    input data_o,
    input header_o,
    input valid_o,
    input frame_err_o,
    input err_cnt_o
  );
endinterface

// File: rtl/ad7771_dout_reader_mc.sv
// rtl/ad7771_dout_reader_mc.sv - multi-lane AD7771 DOUT frame capture, publishes all channels atomically
// Optional build macro AD7771_HDR_CHECK_EN rejects frames whose headers carry a wrong channel id or ADC error flag.
module ad7771_dout_reader_mc #(
  parameter int NUM_CH      = 8,
  parameter int NUM_LANES   = 1,
  parameter int DATA_W      = 24,
  parameter int HDR_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 drdy,
  input  logic                 dclk,
  input  logic [NUM_LANES-1:0] din,
  ad7771_dout_reader_mc_if.master bus
);

  localparam int SLOT_W      = HDR_W + DATA_W;
  localparam int CH_PER_LANE = NUM_CH / NUM_LANES;
  localparam int FRAME_BITS  = CH_PER_LANE * SLOT_W;
  localparam int CNT_W       = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0]                drdy_sync;
  logic [SYNC_STAGES-1:0]                dclk_sync;
  logic [SYNC_STAGES-1:0][NUM_LANES-1:0] din_sync;
  logic                                  drdy_hist;
  logic                                  dclk_hist;
  logic                                  drdy_fall;
  logic                                  dclk_fall;
  logic [NUM_LANES-1:0]                  din_s;

  state_t                                state;
  logic [CNT_W-1:0]                      bit_cnt;
  logic [NUM_LANES-1:0][FRAME_BITS-1:0]  lane_sr;

  logic [NUM_CH*DATA_W-1:0]              data_r;
  logic [NUM_CH*HDR_W-1:0]               header_r;
  logic                                  valid_r;
  logic                                  frame_err_r;
  logic [15:0]                           err_cnt_r;

  logic [NUM_CH*DATA_W-1:0]              pub_data;
  logic [NUM_CH*HDR_W-1:0]               pub_hdr;
  logic                                  hdr_bad;
  logic [SLOT_W-1:0]                     slot;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      drdy_sync <= '0;
      dclk_sync <= '0;
      din_sync  <= '0;
      drdy_hist <= 1'b0;
      dclk_hist <= 1'b0;
    end else begin
      drdy_sync <= {drdy_sync[SYNC_STAGES-2:0], drdy};
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], dclk};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
      drdy_hist <= drdy_sync[SYNC_STAGES-1];
      dclk_hist <= dclk_sync[SYNC_STAGES-1];
    end
  end

  // din shares the dclk pipeline depth, so din_s is the level present at the physical DCLK fall
  assign drdy_fall = drdy_hist & ~drdy_sync[SYNC_STAGES-1];
  assign dclk_fall = dclk_hist & ~dclk_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];

  // First bit shifted in ends at the MSB, so slot 0 of each lane sits at the top of its register
  always_comb begin
    pub_data = '0;
    pub_hdr  = '0;
    hdr_bad  = 1'b0;
    slot     = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int j = 0; j < CH_PER_LANE; j++) begin
        slot = lane_sr[l][(CH_PER_LANE-1-j)*SLOT_W +: SLOT_W];
        pub_hdr[(l*CH_PER_LANE+j)*HDR_W +: HDR_W]    = slot[SLOT_W-1 -: HDR_W];
        pub_data[(l*CH_PER_LANE+j)*DATA_W +: DATA_W] = slot[DATA_W-1:0];
`ifdef AD7771_HDR_CHECK_EN
        if (slot[DATA_W+7] || (slot[DATA_W+6 -: 3] != 3'(l*CH_PER_LANE+j)))
          hdr_bad = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      lane_sr     <= '0;
      data_r      <= '0;
      header_r    <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      err_cnt_r   <= '0;
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (drdy_fall) begin
            bit_cnt <= '0;
            lane_sr <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // A new /DRDY mid-frame wins over any DCLK fall in the same cycle
          if (drdy_fall) begin
            frame_err_r <= 1'b1;
            if (err_cnt_r != 16'hFFFF)
              err_cnt_r <= err_cnt_r + 16'd1;
            bit_cnt <= '0;
            lane_sr <= '0;
          end else if (dclk_fall) begin
            for (int l = 0; l < NUM_LANES; l++)
              lane_sr[l] <= {lane_sr[l][FRAME_BITS-2:0], din_s[l]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT)
              state <= PUBLISH;
          end
        end
        PUBLISH: begin
          if (!hdr_bad) begin
            data_r   <= pub_data;
            header_r <= pub_hdr;
            valid_r  <= 1'b1;
          end else begin
            frame_err_r <= 1'b1;
            if (err_cnt_r != 16'hFFFF)
              err_cnt_r <= err_cnt_r + 16'd1;
          end
          // Publish still completes; a /DRDY seen here starts the next frame directly
          if (drdy_fall) begin
            bit_cnt <= '0;
            lane_sr <= '0;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_o      = data_r;
  assign bus.header_o    = header_r;
  assign bus.valid_o     = valid_r;
  assign bus.frame_err_o = frame_err_r;
  assign bus.err_cnt_o   = err_cnt_r;

endmodule
